lif_column_neuron: RTL

LIF_COLUMN_NEURON -- requirements
Module: lif_column_neuron

---
 rtl/snn_pkg.sv | 15 +
 rtl/lif_update.sv | 22 ++
 rtl/lif_column_neuron.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN column: FSM state encoding and
// the channel-index width used by both the PE array and the neuron.
package snn_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      FIRE  = 1'b1
   } lif_state_e;

   // Width of a channel index; one spare bit so out-of-range indices are representable
   function automatic int chan_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational LIF membrane update: leak, integrate, threshold compare,
// and soft reset by subtracting the threshold on a spike.
module lif_update #(
   parameter shortreal BETA      = 0.9,
   parameter shortreal THRESHOLD = 1.0
) (
   input  shortreal mem_in,
   input  shortreal cur_in,
   output logic     spike,
   output shortreal mem_next
);

   shortreal m;

   // m = BETA*mem + cur; fire when m reaches THRESHOLD and keep the residue
   always_comb begin
      m        = BETA * mem_in + cur_in;
      spike    = (m >= THRESHOLD);
      mem_next = spike ? (m - THRESHOLD) : m;
   end

endmodule

// File: rtl/lif_column_neuron.sv
// Time-multiplexed LIF neuron at the bottom of a PE column. Partial sums
// are accumulated per output channel during ACCUM; a transit pulse starts
// FIRE, which updates one channel per cycle and emits registered results.
//
// Handshake: psum_valid is a one-cycle qualifier with no back-pressure.
// A psum is taken only in ACCUM with oc_phase < OUT_CHANNELS; any other
// asserted psum_valid is dropped and latches the sticky err flag.
module lif_column_neuron
   import snn_pkg::*;
#(
   parameter int       OUT_CHANNELS = 2,
   parameter shortreal BETA         = 0.9,
   parameter shortreal THRESHOLD    = 1.0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              transit,
   input  logic                              sample_start,
   input  shortreal                          psum_in,
   input  logic                              psum_valid,
   input  logic [chan_w(OUT_CHANNELS)-1:0]   oc_phase,
   output logic                              spike_out,
   output logic                              spike_valid,
   output logic [chan_w(OUT_CHANNELS)-1:0]   spike_oc,
   output shortreal                          mem_out,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);

   localparam int            CW      = chan_w(OUT_CHANNELS);
   localparam logic [CW-1:0] NCH     = CW'(OUT_CHANNELS);
   localparam logic [CW-1:0] LAST_CH = CW'(OUT_CHANNELS - 1);

   lif_state_e    state;
   lif_state_e    state_next;
   logic [CW-1:0] k;

   shortreal cur [OUT_CHANNELS];
   shortreal mem [OUT_CHANNELS];

   shortreal cur_k;
   shortreal mem_k;
   shortreal mem_upd;
   logic     spike_upd;

   logic in_range;
   logic accept;
   logic fire_step;

   assign in_range  = (oc_phase < NCH);
   assign accept    = psum_valid && in_range && (state == ACCUM);
   // sample_start aborts FIRE before the current channel is touched
   assign fire_step = (state == FIRE) && !sample_start;
   assign busy      = (state == FIRE);

   // Select the channel being fired this cycle
   always_comb begin
      cur_k = 0.0;
      mem_k = 0.0;
      for (int i = 0; i < OUT_CHANNELS; i++) begin
         if (CW'(i) == k) begin
            cur_k = cur[i];
            mem_k = mem[i];
         end
      end
   end

   lif_update #(
      .BETA      (BETA),
      .THRESHOLD (THRESHOLD)
   ) u_update (
      .mem_in   (mem_k),
      .cur_in   (cur_k),
      .spike    (spike_upd),
      .mem_next (mem_upd)
   );

   // Next-state logic: sample_start wins over transit and aborts FIRE
   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (transit && !sample_start) state_next = FIRE;
         FIRE:    if (sample_start || (k == LAST_CH)) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_next;
   end

   // Channel counter: walks 0..LAST_CH during FIRE, parked at 0 otherwise
   always_ff @(posedge clk) begin
      if (rst)                            k <= '0;
      else if (fire_step && k != LAST_CH) k <= k + 1'b1;
      else                                k <= '0;
   end

   // Per-channel current and membrane storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OUT_CHANNELS; i++) begin
            cur[i] <= 0.0;
            mem[i] <= 0.0;
         end
      end else begin
         for (int i = 0; i < OUT_CHANNELS; i++) begin
            if (sample_start) begin
               cur[i] <= 0.0;
               mem[i] <= 0.0;
            end else if (fire_step && CW'(i) == k) begin
               cur[i] <= 0.0;
               mem[i] <= mem_upd;
            end
            // A psum in the sample_start cycle lands on the zeroed current
            if (accept && CW'(i) == oc_phase)
               cur[i] <= sample_start ? psum_in : cur[i] + psum_in;
         end
      end
   end

   // Registered result outputs, done pulse and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         spike_out   <= 1'b0;
         spike_valid <= 1'b0;
         spike_oc    <= '0;
         mem_out     <= 0.0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         spike_valid <= fire_step;
         if (fire_step) begin
            spike_out <= spike_upd;
            spike_oc  <= k;
            mem_out   <= mem_upd;
         end
         // The cycle after the last channel's result is on the outputs
         done <= spike_valid && (spike_oc == LAST_CH);
         if (psum_valid && ((state == FIRE) || !in_range))
            err <= 1'b1;
      end
   end

endmodule
